// File: rtl/pipe_reg.sv
// Elastic pipeline register: a chain of STAGES data registers with per-stage
// valid bits, valid/ready on both sides, global stall/flush and bubble collapse.
module pipe_reg #(
  parameter int               WIDTH     = 32,
  parameter int               STAGES    = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        stall,
  input  logic                        flush,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [WIDTH-1:0]            in_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [WIDTH-1:0]            out_data,
  output logic [$clog2(STAGES+1)-1:0] count
);

  localparam int CW = $clog2(STAGES + 1);

  // Handshake: a word transfers on a side exactly in a cycle where both valid
  // and ready are high at the rising edge; neither ready nor valid waits on the
  // other, and both are forced low while stall or flush is asserted.

  logic [STAGES-1:0] v_q, v_d;
  logic [WIDTH-1:0]  d_q [STAGES];
  logic [CW-1:0]     count_q, count_d;

  logic [STAGES-1:0] move;
  logic [STAGES-1:0] free;
  logic              hold;
  logic              in_xfer;

  assign hold = stall | flush;

  // Walk from the output end back towards stage 0 so a stage can see whether
  // the stage ahead of it is emptying in this same cycle.
  always_comb begin
    move = '0;
    free = '0;
    move[STAGES-1] = v_q[STAGES-1] & out_ready & ~hold;
    free[STAGES-1] = ~v_q[STAGES-1] | move[STAGES-1];
    for (int i = STAGES - 2; i >= 0; i--) begin
      move[i] = v_q[i] & free[i+1] & ~hold;
      free[i] = ~v_q[i] | move[i];
    end
  end

  assign in_ready  = free[0] & ~hold;
  assign in_xfer   = in_valid & in_ready;
  assign out_valid = v_q[STAGES-1] & ~hold;
  assign out_data  = d_q[STAGES-1];
  assign count     = count_q;

  always_comb begin
    v_d    = v_q;
    v_d[0] = in_xfer | (v_q[0] & ~move[0]);
    for (int i = 1; i < STAGES; i++) begin
      v_d[i] = move[i-1] | (v_q[i] & ~move[i]);
    end
    if (flush) begin
      v_d = '0;
    end
  end

  always_comb begin
    count_d = '0;
    for (int i = 0; i < STAGES; i++) begin
      count_d = count_d + CW'(v_d[i]);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      v_q     <= '0;
      count_q <= '0;
    end else begin
      v_q     <= v_d;
      count_q <= count_d;
    end
  end

  // Data registers only ever load; an emptied stage keeps its stale payload.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < STAGES; i++) begin
        d_q[i] <= RESET_VAL;
      end
    end else begin
      if (in_xfer) begin
        d_q[0] <= in_data;
      end
      for (int i = 1; i < STAGES; i++) begin
        if (move[i-1]) begin
          d_q[i] <= d_q[i-1];
        end
      end
    end
  end

endmodule

// File: doc/pipe_reg.md
# pipe_reg

Parametrised elastic pipeline register: a chain of `STAGES` data registers with per-stage valid bits, valid/ready handshake on both sides, and global stall and flush controls. It replaces the bare D-register between CPU pipeline stages (IF/ID, ID/EX, EX/MEM, MEM/WB), so hazard and branch logic can freeze or squash a stage without extra glue. Bubbles collapse: an empty stage is filled even when the output is blocked.

## Interface
- `WIDTH`, 32, payload width in bits
- `STAGES`, 1, number of register stages (≥1)
- `RESET_VAL`, 0, value loaded into every data register on reset
- `clk` input 1, rising-edge clock
- `reset` input 1, asynchronous, active-high; clears all valid bits and loads `RESET_VAL` into all data registers
- `stall` input 1, freezes all stages and both handshakes while high
- `flush` input 1, squashes all in-flight entries; has priority over `stall`
- `in_valid` input 1, upstream has data
- `in_ready` output 1, block can accept data this cycle
- `in_data` input WIDTH, upstream payload
- `out_valid` output 1, stage `STAGES-1` holds data
- `out_ready` input 1, downstream accepts data this cycle
- `out_data` output WIDTH, payload of stage `STAGES-1`
- `count` output $clog2(STAGES+1), number of valid stages

## Operation
- Stage 0 is on the input side and stage `STAGES-1` drives the outputs. Each stage i has `v[i]` and `d[i]`.
- Per-stage moves (all combinational):
  - Output stage: `move[S-1] = v[S-1] & out_ready & !stall & !flush`.
  - Other stages: `move[i] = v[i] & free[i+1] & !stall & !flush`, where `free[i] = !v[i] | move[i]`.
- `in_ready = free[0] & !stall & !flush`. An input transfer is `in_valid & in_ready`.
- `out_valid = v[S-1] & !stall & !flush`. `out_data = d[S-1]` unconditionally.
- On each clock edge, for i>0:
  - `v[i]` becomes `move[i-1] | (v[i] & !move[i])`.
  - `d[i]` loads `d[i-1]` only when `move[i-1]`.
- Stage 0 loads `in_data` on an input transfer. Its valid bit is set by the transfer and cleared by `move[0]`.
- Data registers never change except by a load or by reset. An empty stage retains stale data.
- `flush`: on the next edge all `v[i]` clear, and no transfer occurs in the flush cycle. Data registers are untouched.
- `stall` without `flush`: no state changes. `in_ready` and `out_valid` are 0.
- `count` is the popcount of the registered `v[]`, updated with them.
- Reset mid-operation: all state clears immediately and asynchronously, without waiting for a clock edge. `in_ready` then follows `!stall & !flush`.

## Timing
- Reset values: `out_valid`=0, `out_data`=`RESET_VAL`, `count`=0, `in_ready`=`!stall & !flush`.
- Latency: a word accepted at edge k is visible on `out_valid`/`out_data` in the cycle after edge k+STAGES-1. For `STAGES`=1, it is visible the cycle after acceptance.
- Throughput: 1 word/cycle when `out_ready` is held high and there is no stall.
- Full (all `v`=1, `out_ready`=0): `in_ready`=0, holds indefinitely.
- Full with `out_ready`=1: output and input transfer in the same cycle. `count` is unchanged.
- Blocked output with empty upstream stages: words advance until they are contiguous at the output end (bubble collapse).
- Simultaneous `flush` and `in_valid`: the input is dropped (`in_ready`=0). `count`=0 after the edge.
- `flush` and `stall` both high: the flush behaviour applies.
- `count` never exceeds `STAGES` and never underflows.

## Test plan
- Reset, `STAGES`=3, `RESET_VAL`=32'hDEAD_BEEF, then release reset -> `out_data`=32'hDEADBEEF, `out_valid`=0, `count`=0, `in_ready`=1. Reset asserted mid-stream between edges -> outputs clear immediately.
- `STAGES`=3, `out_ready`=1, inputs 1,2,3,4 on consecutive cycles -> `out_valid` first high 3 cycles after accepting 1. Output sequence is 1,2,3,4 back-to-back. `count` peaks at 3.
- `STAGES`=3, `out_ready`=0, push 0xA,0xB,0xC,0xD -> 0xD is refused (`in_ready`=0) and `count`=3. Raise `out_ready` for 1 cycle -> 0xA leaves and 0xD is accepted in the same cycle.
- Single word 0x55 with `out_ready`=0 in a 4-stage pipe -> reaches stage 3 after 3 edges. Push 0x66 -> it collapses to stage 2 and `count`=2.
- Hold `stall` 5 cycles with 2 words in flight -> `in_ready`=0, `out_valid`=0, `count` steady at 2. Release -> the words drain in order.
- `flush` with 3 words in flight, `in_valid`=1 and `stall`=1 -> after the edge `count`=0, `out_valid`=0, and no word is accepted or emitted in the flush cycle.
